// File: rtl/cmp1b_stim_checker.sv
// Self-test driver/monitor for a 1-bit equality comparator: walks {a,b} = 00..11,
// samples y at the end of each hold window and reports mismatch count and pass/fail.
module cmp1b_stim_checker #(
  parameter int unsigned HOLD_W      = 8,
  parameter int unsigned HOLD_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] vec_idx,
  output logic       mismatch
);

  localparam int unsigned ERR_W = 3;
  localparam int unsigned IDX_W = 2;

  // A zero or over-wide hold length would make the counter meaningless.
  if (HOLD_CYCLES == 0 || 64'(HOLD_CYCLES) > ((64'(1) << HOLD_W) - 64'(1))) begin : g_bad_hold
    $error("cmp1b_stim_checker: HOLD_CYCLES must be in 1 .. 2**HOLD_W-1");
  end

  localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]   vec_idx_q, vec_idx_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               mismatch_q, mismatch_d;

  logic               hit;
  logic [ERR_W-1:0]   err_nxt;
  logic [IDX_W-1:0]   idx_inc;

  // y is combinational from the registered a/b currently on the wires.
  assign hit     = (y != ~(a_q ^ b_q));
  assign idx_inc = IDX_W'(vec_idx_q + IDX_W'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vec_idx_d  = vec_idx_q;
    err_cnt_d  = err_cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    mismatch_d = 1'b0;
    err_nxt    = hit ? ERR_W'(err_cnt_q + ERR_W'(1)) : err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d   = ST_RUN;
          vec_idx_d = '0;
          cnt_d     = RELOAD;
          err_cnt_d = '0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
        end
      end

      ST_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = HOLD_W'(cnt_q - HOLD_W'(1));
        end else begin
          err_cnt_d  = err_nxt;
          mismatch_d = hit;
          if (vec_idx_q != 2'd3) begin
            vec_idx_d = idx_inc;
            cnt_d     = RELOAD;
            a_d       = idx_inc[1];
            b_d       = idx_inc[0];
          end else begin
            state_d   = ST_DONE;
            pass_d    = (err_nxt == '0);
            vec_idx_d = '0;
            a_d       = 1'b0;
            b_d       = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      vec_idx_q  <= '0;
      err_cnt_q  <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vec_idx_q  <= vec_idx_d;
      err_cnt_q  <= err_cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign vec_idx  = vec_idx_q;
  assign mismatch = mismatch_q;

endmodule

// File: doc/cmp1b_stim_checker.md
# cmp1b_stim_checker

Self-checking driver/monitor for the 1-bit equality comparator (`y = (a == b)`). On `start` it walks the four input vectors {a,b} = 00, 01, 10, 11. It holds each vector for a programmable number of cycles and samples the comparator's `y` at the end of each hold. It counts mismatches against the expected value `a XNOR b` and reports pass/fail. It is the synthesizable counterpart of the comparator's bench: it drives the comparator's inputs and consumes its output, for on-board or in-system self-test.

## Interface
- `HOLD_W`, 8, width of the hold counter.
- `HOLD_CYCLES`, 100, cycles each vector is held. Legal range 1 .. 2^HOLD_W-1; 0 is illegal and must fail elaboration.

- `clk`  input  1  system clock; everything is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  level-sampled; begins a run when the block is in IDLE.
- `y`  input  1  comparator output; combinational from `a`/`b`.
- `a`  output  1  comparator input a; registered.
- `b`  output  1  comparator input b; registered.
- `busy`  output  1  high while vectors are being applied.
- `done`  output  1  one-cycle pulse at run completion.
- `pass`  output  1  high if the last run had zero mismatches; held until the next start or reset.
- `err_cnt`  output  3  mismatch count of the current/last run, range 0..4.
- `vec_idx`  output  2  index of the vector currently driven.
- `mismatch`  output  1  one-cycle pulse after a failing sample.

## Operation
- The only reset is synchronous active-high `rst`.
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `vec_idx`=0, `mismatch`=0, state IDLE.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - `a`=`b`=0.
  - If `start`=1 at an edge: `vec_idx`←0, hold counter←HOLD_CYCLES-1, `err_cnt`←0, `pass`←0, state←RUN.
- RUN:
  - Drive `a`=`vec_idx[1]`, `b`=`vec_idx[0]`; `busy`=1.
  - At each edge, if counter≠0: decrement.
  - If counter=0, sample `y` and compare it to `~(a ^ b)`, giving expected values 1, 0, 0, 1 for indices 0..3.
    - On mismatch: `err_cnt`+1 and `mismatch` pulses for the following cycle.
  - After the compare, if `vec_idx`<3: `vec_idx`+1 and counter reloads HOLD_CYCLES-1.
  - If `vec_idx`=3: state←DONE.
    - `pass`←(final `err_cnt`==0), including any mismatch from this last compare.
    - `a`/`b`←0 and `vec_idx`←0.
- DONE:
  - Lasts exactly one cycle, with `done`=1 and `busy`=0.
  - The next edge always goes to IDLE; `start` is ignored in DONE.
- `start` is ignored in RUN and DONE; there is no restart or abort except via `rst`.
- `err_cnt` cannot exceed 4 (3 bits, no wrap possible). It holds its final value in IDLE until the next start.
- Reset mid-run: at the `rst` edge all outputs take their reset values. The run is abandoned, with no `done` pulse and `pass`=0.
- `rst` and `start` high at the same edge: `rst` wins.

## Timing
- Let E0 be the edge where `start` is accepted.
- Vector k is driven during the cycles following edges E0+k·H through E0+(k+1)·H-1, i.e. exactly H = HOLD_CYCLES cycles.
- Vector k is sampled at edge E0+(k+1)·H.
- `busy` is high from E0 to E0+4H.
- `done` is high in the cycle following E0+4H.
- `pass` is valid from E0+4H.
- IDLE is re-entered at E0+4H+1. A `start` seen at that edge is not accepted (block is in DONE); the earliest new acceptance is E0+4H+2.
- `mismatch` for vector k is high in the cycle after edge E0+(k+1)·H. `err_cnt` updates at the same edge.
- With H=1, the vector changes every cycle and a run takes 4 cycles plus 1 DONE cycle.

## Test plan
- Correct comparator model, HOLD_CYCLES=4, `start` pulsed at E0:
  - {a,b} = 00, 01, 10, 11, each for 4 cycles.
  - `done` pulse at E0+16.
  - `pass`=1, `err_cnt`=0, no `mismatch` pulses.
- `y` stuck at 0: `mismatch` pulses after E0+4 and E0+16; `err_cnt`=2, `pass`=0.
- `y` inverted (`a^b`): four `mismatch` pulses; `err_cnt`=4, `pass`=0, with no counter wrap.
- `rst` asserted while `vec_idx`=2:
  - Next edge gives `a`=`b`=0, `busy`=0, `err_cnt`=0, `pass`=0, no `done`.
  - A new `start` re-runs from vector 0.
- `start` held high throughout:
  - `start` during RUN is ignored, with no vector restart.
  - A new run is accepted at E0+4H+2 and `err_cnt` clears there.
  - `pass` from the prior run is cleared to 0 at that acceptance edge.
- HOLD_CYCLES=1:
  - Vectors change every cycle and samples occur at E0+1..E0+4.
  - `done` at E0+4; correct DUT gives `pass`=1.
